// File: rtl/iter_mul_unit.sv
// Iterative shift-and-add multiplier for RV32M MUL/MULH/MULHSU/MULHU.
// Magnitudes are multiplied over WIDTH RUN cycles; one FIX cycle applies the sign.
module iter_mul_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             result_valid,
   input  logic             result_ready,
   output logic [WIDTH-1:0] result,
   output logic             busy
);
   localparam int unsigned CntW = $clog2(WIDTH);

   typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_e;

   state_e           r_state;
   logic [1:0]       r_op;
   logic             r_neg;
   logic [WIDTH-1:0] r_mag_a;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;
   logic [CntW-1:0]  r_cnt;
   logic             r_result_valid;
   logic [WIDTH-1:0] r_result;
   logic             r_busy;

   logic               w_a_signed;
   logic               w_b_signed;
   logic [WIDTH-1:0]   w_abs_a;
   logic [WIDTH-1:0]   w_abs_b;
   logic [WIDTH:0]     w_sum;
   logic [2*WIDTH-1:0] w_acc;
   logic [2*WIDTH-1:0] w_prod;

   always_comb begin
      w_a_signed = (op == 2'b01) || (op == 2'b10);
      w_b_signed = (op == 2'b01);
      // Most-negative value negates to itself, which is the correct unsigned magnitude.
      w_abs_a    = (w_a_signed && a[WIDTH-1]) ? -a : a;
      w_abs_b    = (w_b_signed && b[WIDTH-1]) ? -b : b;
      w_sum      = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mag_a} : '0);
      w_acc      = {r_hi, r_lo};
      w_prod     = r_neg ? -w_acc : w_acc;
   end

   assign start_ready  = (r_state == StIdle);
   assign result_valid = r_result_valid;
   assign result       = r_result;
   assign busy         = r_busy;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state        <= StIdle;
         r_op           <= 2'b00;
         r_neg          <= 1'b0;
         r_mag_a        <= '0;
         r_hi           <= '0;
         r_lo           <= '0;
         r_cnt          <= '0;
         r_result_valid <= 1'b0;
         r_result       <= '0;
         r_busy         <= 1'b0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (start_valid) begin
                  r_op    <= op;
                  r_mag_a <= w_abs_a;
                  r_neg   <= (w_a_signed & a[WIDTH-1]) ^ (w_b_signed & b[WIDTH-1]);
                  r_hi    <= '0;
                  r_lo    <= w_abs_b;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= StRun;
               end
            end
            StRun: begin
               // Shift right by one with the adder carry entering the MSB.
               r_hi  <= w_sum[WIDTH:1];
               r_lo  <= {w_sum[0], r_lo[WIDTH-1:1]};
               r_cnt <= r_cnt + CntW'(1);
               if (r_cnt == CntW'(WIDTH - 1)) begin
                  r_state <= StFix;
               end
            end
            StFix: begin
               r_result       <= (r_op == 2'b00) ? w_prod[WIDTH-1:0] : w_prod[2*WIDTH-1:WIDTH];
               r_result_valid <= 1'b1;
               r_state        <= StDone;
            end
            StDone: begin
               if (result_ready) begin
                  r_result_valid <= 1'b0;
                  r_busy         <= 1'b0;
                  r_state        <= StIdle;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

endmodule
